display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Time-multiplexes the four-digit 7-segment display, sharing the SegA–SegG/DP lines among the nDigit[3:0] common drivers. Sits inside comp_core between the measurement/mode datapath and the segment/digit pad outputs. Accepts new display values through a valid/ready handshake and swaps them in only at frame boundaries, so a frame never tears. Inserts a blanking gap before each digit to stop ghosting and applies leading-zero blanking.

Parameters:
DIGIT_CYCLES, 32, Clock cycles per digit slot (frame = 4*DIGIT_CYCLES); must be a power of two, ≥4.
BLANK_CYCLES, 2, Cycles at the start of each slot with all digits off; must satisfy 1 ≤ BLANK_CYCLES < DIGIT_CYCLES.

Ports:
Clock  input  1  system clock
nReset  input  1  reset; asynchronous, active-low
val_data  input  16  four BCD/code nibbles; [3:0]=digit0 (rightmost) … [15:12]=digit3
val_dp  input  4  decimal-point enable per digit, bit i = digit i
val_lzb  input  1  leading-zero blanking enable for this value
val_valid  input  1  new value offered
val_ready  output  1  pending buffer can accept
nDigit  output  4  digit drivers, active-low, at most one low
Seg  output  7  segments {G,F,E,D,C,B,A}, active-high
DP  output  1  decimal point, active-high
frame_tick  output  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Reset (async, nReset=0): nDigit=4'b1111, Seg=0, DP=0, frame_tick=0, val_ready=1; slot counter=0, digit index=0, phase=BLANK; display register = all nibbles 4'hF with dp=0 and lzb=0; pending buffer empty. The blank display register leaves every digit dark. Reset mid-frame aborts the frame immediately.
- FSM per slot: BLANK for BLANK_CYCLES cycles (nDigit=1111, Seg=0, DP=0) -> ON for DIGIT_CYCLES-BLANK_CYCLES cycles (nDigit[idx]=0, Seg/DP from digit idx) -> BLANK of slot idx+1.
- Digit order 0,1,2,3, wrapping 3->0. The counter is $clog2(DIGIT_CYCLES) bits wide and wraps naturally.
- All outputs are registered. The output tracks the internal state with one cycle of latency.
- frame_end = last cycle of digit 3 ON. frame_tick is asserted in the cycle after frame_end (registered).
- Handshake: a transfer occurs when val_valid && val_ready.
  - val_ready = !pending_full || frame_end.
  - The captured value goes into the pending buffer.
  - At frame_end, if the pending buffer is full, it is copied into the display register and the buffer is marked empty, except when a transfer occurs in the same cycle, which refills the buffer.
  - Multiple accepted values within a frame: only possible when the buffer is empty, so the second offer stalls (ready low) until frame_end.
- Decode: 0–9 digits; A,b,C,d,E hex forms for 0xA–0xE; 0xF = blank (Seg=0).
- Leading-zero blanking (when lzb=1): digit k (k=3..1) is blanked if its nibble is 0 and all higher digits are blanked or zero. Digit 0 is never zero-blanked.
- DP is independent of blanking: a set dp bit lights even on a blanked digit.

Optional Feature:
DISPLAY_DIM_EN: adds input port dim (1 bit).
- When dim=1, the ON phase is shortened to its last (DIGIT_CYCLES-BLANK_CYCLES)/4 cycles (minimum 1); the remaining cycles stay BLANK.
- Slot and frame length are unchanged.
- dim is sampled at the start of each slot.
Without the macro there is no dim port and the ON phase is always full length.

Decomposition:
- Package disp_pkg holds:
  - constant NUM_DIGITS=4
  - typedef seg_t (logic [6:0])
  - typedef disp_val_t struct {nibbles[4], dp[4], lzb}
  - enum scan_phase_t {BLANK, ON}
  - SEG_BLANK, and segment-code constants for 0–F
- Sub-module seg7_decode: combinational, nibble + blank flag -> seg_t. It is instantiated once on the muxed digit.

Test Plan:
- Reset release with no value, DIGIT_CYCLES=32, BLANK_CYCLES=2 -> nDigit stays 1111 and Seg=0 for 2 full frames (256 cycles); frame_tick pulses every 128 cycles.
- Load val_data=16'h1234, dp=4'b0100, lzb=0 mid-frame -> the display is unchanged until the next frame_tick. The following frame shows digit0 Seg=7'h66 ('4'), digit1 '3', digit2 '2' with DP=1, digit3 '1'. Each digit is low for 30 cycles, preceded by 2 all-off cycles.
- val_data=16'h0070, lzb=1 -> digits 3 and 2 are dark, digit1 '7', digit0 '0' (Seg=7'h3F). With lzb=0, digit3 and digit2 show '0'.
- Two back-to-back offers within one frame -> the first is accepted; val_ready stays low for the second until the frame_end cycle, where it is accepted while the first moves to the display register. The second value is displayed one frame later.
- Assert nReset=0 during digit2 ON -> nDigit=1111, Seg=0, and val_ready=1 in the same cycle, with no clock edge needed. After release, scanning restarts at digit0 BLANK with a blank display.
- With DISPLAY_DIM_EN defined and dim=1 -> each digit is low for 7 cycles (the last 7 of its slot); the frame length is still 128 cycles.

Source files
------------

// File: rtl/disp_pkg.sv
// disp_pkg: shared types and segment glyph constants for the display scanner.
package disp_pkg;

   localparam int NUM_DIGITS = 4;

   // Segment vector ordered {G,F,E,D,C,B,A}, active-high.
   typedef logic [6:0] seg_t;

   // One complete display value: four nibbles, per-digit decimal points and
   // the leading-zero blanking enable that travels with the value.
   typedef struct packed {
      logic [NUM_DIGITS-1:0][3:0] nibbles;
      logic [NUM_DIGITS-1:0]      dp;
      logic                       lzb;
   } disp_val_t;

   typedef enum logic {
      BLANK = 1'b0,
      ON    = 1'b1
   } scan_phase_t;

   localparam seg_t SEG_BLANK = 7'h00;
   localparam seg_t SEG_0     = 7'h3F;
   localparam seg_t SEG_1     = 7'h06;
   localparam seg_t SEG_2     = 7'h5B;
   localparam seg_t SEG_3     = 7'h4F;
   localparam seg_t SEG_4     = 7'h66;
   localparam seg_t SEG_5     = 7'h6D;
   localparam seg_t SEG_6     = 7'h7D;
   localparam seg_t SEG_7     = 7'h07;
   localparam seg_t SEG_8     = 7'h7F;
   localparam seg_t SEG_9     = 7'h6F;
   localparam seg_t SEG_A     = 7'h77;
   localparam seg_t SEG_B     = 7'h7C;
   localparam seg_t SEG_C     = 7'h39;
   localparam seg_t SEG_D     = 7'h5E;
   localparam seg_t SEG_E     = 7'h79;
   localparam seg_t SEG_F     = SEG_BLANK;

   // All nibbles 0xF (dark), no decimal points, no zero blanking.
   localparam disp_val_t DISP_RESET = {16'hFFFF, 4'h0, 1'b0};

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational nibble-to-segment decoder with a blank override.
module seg7_decode
   import disp_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output seg_t       seg
);

   // Map the nibble to its glyph; code 0xF and the blank flag both go dark.
   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
         endcase
      end
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: four-digit multiplexed 7-segment scanner. New values are
// taken through a valid/ready handshake into a pending buffer and swapped into
// the display register only at the end of a frame, so a frame never tears.
// Optional build macro DISPLAY_DIM_EN adds the dim input, which shortens the
// ON phase of each slot to its final quarter.
module display_scan_ctrl
   import disp_pkg::*;
#(
   parameter int DIGIT_CYCLES = 32,
   parameter int BLANK_CYCLES = 2
) (
   input  logic        Clock,
   input  logic        nReset,
   input  logic [15:0] val_data,
   input  logic [3:0]  val_dp,
   input  logic        val_lzb,
   input  logic        val_valid,
   output logic        val_ready,
`ifdef DISPLAY_DIM_EN
   input  logic        dim,
`endif
   output logic [3:0]  nDigit,
   output seg_t        Seg,
   output logic        DP,
   output logic        frame_tick
);

   localparam int CNT_W   = $clog2(DIGIT_CYCLES);
   localparam int ON_LEN  = DIGIT_CYCLES - BLANK_CYCLES;
   localparam int DIM_LEN = ((ON_LEN / 4) < 1) ? 1 : (ON_LEN / 4);

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t LAST_CNT     = cnt_t'(DIGIT_CYCLES - 1);
   localparam cnt_t ON_START     = cnt_t'(BLANK_CYCLES);
   localparam cnt_t ON_START_DIM = cnt_t'(DIGIT_CYCLES - DIM_LEN);

   cnt_t                  slotCntReg, slotCntNext, onStart;
   logic [1:0]            digitIdxReg, digitIdxNext;
   scan_phase_t           phaseReg, phaseNext;
   disp_val_t             dispReg, pendReg;
   logic                  pendFullReg, pendFullNext;
   logic                  frameEnd, frameEndNext, xfer, dimEff;
   logic [NUM_DIGITS-1:0] zeroBlank;
   logic [3:0]            curNibble;
   seg_t                  curSeg, segNext;
   logic                  curDp, curLit, dpNext;
   logic [3:0]            nDigitNext;

`ifdef DISPLAY_DIM_EN
   logic dimSlotReg;

   // dim is taken from the input in slot cycle 0 and held for the rest of the slot.
   assign dimEff = (slotCntReg == '0) ? dim : dimSlotReg;

   // Remember the dim decision made at the start of the slot.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) dimSlotReg <= 1'b0;
      else         dimSlotReg <= dimEff;
   end
`else
   assign dimEff = 1'b0;
`endif

   // Dimming moves the BLANK->ON point later; the slot ends at the same cycle.
   assign onStart = dimEff ? ON_START_DIM : ON_START;

   // Digit k is zero-blanked when it and every higher nibble are zero.
   assign zeroBlank[0] = 1'b0;
   for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : gZeroBlank
      assign zeroBlank[gi] = dispReg.lzb && (dispReg.nibbles[NUM_DIGITS-1:gi] == '0);
   end

   assign curNibble = dispReg.nibbles[digitIdxReg];
   assign curDp     = dispReg.dp[digitIdxReg];

   seg7_decode uDecode (
      .nibble (curNibble),
      .blank  (zeroBlank[digitIdxReg]),
      .seg    (curSeg)
   );

   // A digit with neither segments nor a decimal point keeps its driver off.
   assign curLit   = (curSeg != SEG_BLANK) || curDp;
   assign frameEnd = (digitIdxReg == 2'd3) && (slotCntReg == LAST_CNT) && (phaseReg == ON);
   assign xfer     = val_valid && val_ready;

   // Next-state for the slot FSM, handshake buffer and the registered outputs.
   always_comb begin
      slotCntNext  = cnt_t'(slotCntReg + 1'b1);
      digitIdxNext = (slotCntReg == LAST_CNT) ? (digitIdxReg + 2'd1) : digitIdxReg;
      phaseNext    = phaseReg;
      case (phaseReg)
         BLANK:   if (slotCntNext == onStart) phaseNext = ON;
         ON:      if (slotCntReg == LAST_CNT) phaseNext = BLANK;
         default: phaseNext = BLANK;
      endcase

      pendFullNext = pendFullReg;
      if (frameEnd)  pendFullNext = xfer;
      else if (xfer) pendFullNext = 1'b1;

      frameEndNext = (digitIdxNext == 2'd3) && (slotCntNext == LAST_CNT) && (phaseNext == ON);

      nDigitNext = 4'b1111;
      segNext    = SEG_BLANK;
      dpNext     = 1'b0;
      if (phaseReg == ON) begin
         nDigitNext[digitIdxReg] = !curLit;
         segNext                 = curSeg;
         dpNext                  = curDp;
      end
   end

   // Slot counter, digit index and phase register.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         slotCntReg  <= '0;
         digitIdxReg <= 2'd0;
         phaseReg    <= BLANK;
      end else begin
         slotCntReg  <= slotCntNext;
         digitIdxReg <= digitIdxNext;
         phaseReg    <= phaseNext;
      end
   end

   // Pending buffer capture and frame-boundary swap into the display register.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         pendReg     <= DISP_RESET;
         pendFullReg <= 1'b0;
         dispReg     <= DISP_RESET;
      end else begin
         if (xfer) pendReg <= {val_data, val_dp, val_lzb};
         if (frameEnd && pendFullReg) dispReg <= pendReg;
         pendFullReg <= pendFullNext;
      end
   end

   // Output registers; val_ready is precomputed so it matches the current state.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         nDigit     <= 4'b1111;
         Seg        <= SEG_BLANK;
         DP         <= 1'b0;
         frame_tick <= 1'b0;
         val_ready  <= 1'b1;
      end else begin
         nDigit     <= nDigitNext;
         Seg        <= segNext;
         DP         <= dpNext;
         frame_tick <= frameEnd;
         val_ready  <= !pendFullNext || frameEndNext;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: table vectors, hand sequences and random traffic
// against a frame-arithmetic reference model of the scanner.
module tb_display_scan_ctrl;

   logic        Clock = 1'b0;
   logic        nReset = 1'b1;
   logic [15:0] val_data;
   logic [3:0]  val_dp;
   logic        val_lzb;
   logic        val_valid;
   logic        val_ready;
   logic [3:0]  nDigit;
   logic [6:0]  Seg;
   logic        DP;
   logic        frame_tick;
`ifdef DISPLAY_DIM_EN
   logic        dim = 1'b0;
`endif

   display_scan_ctrl #(.DIGIT_CYCLES(32), .BLANK_CYCLES(2)) dut (
      .Clock      (Clock),
      .nReset     (nReset),
      .val_data   (val_data),
      .val_dp     (val_dp),
      .val_lzb    (val_lzb),
      .val_valid  (val_valid),
      .val_ready  (val_ready),
`ifdef DISPLAY_DIM_EN
      .dim        (dim),
`endif
      .nDigit     (nDigit),
      .Seg        (Seg),
      .DP         (DP),
      .frame_tick (frame_tick)
   );

   always #5 Clock = ~Clock;

   localparam logic [20:0] BLANK_VAL = {16'hFFFF, 4'h0, 1'b0};

   int errCnt = 0;
   int chkCnt = 0;

   // Reference model: cycles elapsed since reset plus the value sets in play.
   int          mCnt;
   bit          mPendFull;
   logic [20:0] mPend;
   logic [20:0] mDisp;
   bit          lastXfer;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  dp;
      logic        lzb;
      int          dig;
      logic [6:0]  seg;
      logic        dpo;
   } vec_t;

   vec_t tbl[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chkCnt++;
      if (act !== exp) begin
         errCnt++;
         $display("FAIL %s: got %0h expected %0h (model cycle %0d)", name, act, exp, mCnt);
      end
   endtask

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h00;
      endcase
   endfunction

   function automatic bit isFrameEnd(input int c);
      return (c % 128) == 127;
   endfunction

   // Expected {nDigit, Seg, DP, frame_tick} for model cycle c showing value v.
   function automatic logic [12:0] expOut(input int c, input logic [20:0] v);
      int pos = c % 128;
      int dig = pos / 32;
      int off = pos % 32;
      int top = 0;
      logic [3:0] nD = 4'hF;
      logic [6:0] sg = 7'h00;
      logic       dpo = 1'b0;
      logic [3:0] nib = v[5 + 4*dig +: 4];
      for (int k = 3; k >= 1; k--) begin
         if (v[5 + 4*k +: 4] != 4'h0) begin
            top = k;
            break;
         end
      end
      if (off >= 2) begin
         sg  = (v[0] && dig > top) ? 7'h00 : glyph(nib);
         dpo = v[1 + dig];
         if (sg != 7'h00 || dpo) nD[dig] = 1'b0;
      end
      return {nD, sg, dpo, isFrameEnd(c)};
   endfunction

   function automatic bit modelReady();
      return !mPendFull || isFrameEnd(mCnt);
   endfunction

   task automatic modelReset();
      mCnt = 0; mPendFull = 0; mPend = BLANK_VAL; mDisp = BLANK_VAL; lastXfer = 0;
   endtask

   function automatic logic [20:0] randVal();
      logic [15:0] d = 16'($urandom);
      d = d >> (4 * $urandom_range(0, 3));
      return {d, 4'($urandom), 1'($urandom)};
   endfunction

   // One clock: drive inputs, advance the model on the edge, compare after it.
   task automatic stepCycle(input bit valid, input logic [20:0] v);
      logic [12:0] e;
      logic [13:0] expV, actV;
      bit fe, xfer;
      val_valid = valid;
      {val_data, val_dp, val_lzb} = v;
      @(posedge Clock);
      fe   = isFrameEnd(mCnt);
      xfer = valid && modelReady();
      e    = expOut(mCnt, mDisp);
      if (fe) begin
         if (mPendFull) mDisp = mPend;
         mPendFull = xfer;
      end else if (xfer) begin
         mPendFull = 1;
      end
      if (xfer) mPend = v;
      lastXfer = xfer;
      mCnt++;
      #1;
      expV = {e, modelReady()};
      actV = {nDigit, Seg, DP, frame_tick, val_ready};
      check("scan", actV, expV);
   endtask

   task automatic offer(input logic [20:0] v);
      int n = 0;
      do begin
         stepCycle(1, v);
         n++;
      end while (!lastXfer && n < 200);
   endtask

   // Run until the outputs show model slot position target (0..127).
   task automatic gotoState(input int target);
      do stepCycle(0, randVal()); while (((mCnt - 1) % 128) != target);
   endtask

   function automatic vec_t mk(input logic [15:0] d, input logic [3:0] p, input logic z,
                               input int g, input logic [6:0] s, input logic o);
      vec_t r;
      r.data = d; r.dp = p; r.lzb = z; r.dig = g; r.seg = s; r.dpo = o;
      return r;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [13:0] actV, expV;
      logic [20:0] v, cur;
      logic [3:0]  nExp;
      int ticks, readyHigh, n;

      tbl[0]  = mk(16'h1234, 4'b0100, 1'b0, 0, 7'h66, 1'b0);
      tbl[1]  = mk(16'h1234, 4'b0100, 1'b0, 1, 7'h4F, 1'b0);
      tbl[2]  = mk(16'h1234, 4'b0100, 1'b0, 2, 7'h5B, 1'b1);
      tbl[3]  = mk(16'h1234, 4'b0100, 1'b0, 3, 7'h06, 1'b0);
      tbl[4]  = mk(16'h0070, 4'b0000, 1'b1, 3, 7'h00, 1'b0);
      tbl[5]  = mk(16'h0070, 4'b0000, 1'b1, 2, 7'h00, 1'b0);
      tbl[6]  = mk(16'h0070, 4'b0000, 1'b1, 1, 7'h07, 1'b0);
      tbl[7]  = mk(16'h0070, 4'b0000, 1'b1, 0, 7'h3F, 1'b0);
      tbl[8]  = mk(16'h0070, 4'b0000, 1'b0, 3, 7'h3F, 1'b0);
      tbl[9]  = mk(16'h0070, 4'b0000, 1'b0, 2, 7'h3F, 1'b0);
      tbl[10] = mk(16'hABCD, 4'b0000, 1'b0, 3, 7'h77, 1'b0);
      tbl[11] = mk(16'hABCD, 4'b0000, 1'b0, 0, 7'h5E, 1'b0);
      tbl[12] = mk(16'h00E0, 4'b1000, 1'b1, 3, 7'h00, 1'b1);
      tbl[13] = mk(16'h00E0, 4'b1000, 1'b1, 1, 7'h79, 1'b0);
      tbl[14] = mk(16'h0005, 4'b0001, 1'b1, 1, 7'h00, 1'b0);
      tbl[15] = mk(16'h0005, 4'b0001, 1'b1, 0, 7'h6D, 1'b1);

      val_valid = 0; val_data = 0; val_dp = 0; val_lzb = 0;

      // Power-on reset.
      #2 nReset = 1'b0;
      #1;
      actV = {nDigit, Seg, DP, frame_tick, val_ready};
      expV = {4'hF, 7'h00, 1'b0, 1'b0, 1'b1};
      check("reset_state", actV, expV);
      repeat (2) @(posedge Clock);
      #3 nReset = 1'b1;
      modelReset();

      // Two idle frames: dark display, frame_tick every 128 cycles.
      ticks = 0;
      for (int i = 0; i < 256; i++) begin
         stepCycle(0, randVal());
         ticks += int'(frame_tick);
      end
      check("idle_ticks", ticks, 2);

      // Table vectors: load each value, let it settle, probe one digit mid-ON.
      cur = BLANK_VAL;
      for (int i = 0; i < 16; i++) begin
         v = {tbl[i].data, tbl[i].dp, tbl[i].lzb};
         if (v != cur) begin
            gotoState(50);
            offer(v);
            cur = v;
            repeat (300) stepCycle(0, randVal());
         end
         gotoState(tbl[i].dig * 32 + 10);
         nExp = 4'hF;
         if (tbl[i].seg != 7'h00 || tbl[i].dpo) nExp[tbl[i].dig] = 1'b0;
         check($sformatf("tbl%0d_seg", i), Seg, tbl[i].seg);
         check($sformatf("tbl%0d_dp", i), DP, tbl[i].dpo);
         check($sformatf("tbl%0d_ndigit", i), nDigit, nExp);
      end

      // Back-to-back offers within one frame.
      gotoState(40);
      check("b2b_ready_before", val_ready, 1);
      offer({16'h5678, 4'b0000, 1'b0});
      readyHigh = 0;
      n = 0;
      do begin
         readyHigh += int'(val_ready);
         stepCycle(1, {16'h9012, 4'b0010, 1'b0});
         n++;
      end while (!lastXfer && n < 200);
      check("b2b_ready_pulses", readyHigh, 1);
      gotoState(10);
      check("b2b_first_shown", Seg, 7'h7F);
      gotoState(10);
      check("b2b_second_shown", Seg, 7'h5B);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) stepCycle($urandom_range(0, 19) == 0, randVal());

      // Asynchronous reset during digit 2 ON with a value pending.
      gotoState(127);
      offer({16'h8888, 4'b1111, 1'b0});
      gotoState(74);
      check("pre_reset_ready", val_ready, 0);
      #2 nReset = 1'b0;
      #1;
      actV = {nDigit, Seg, DP, frame_tick, val_ready};
      expV = {4'hF, 7'h00, 1'b0, 1'b0, 1'b1};
      check("async_reset", actV, expV);
      repeat (2) @(posedge Clock);
      #3 nReset = 1'b1;
      modelReset();
      repeat (300) stepCycle(0, randVal());

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

endmodule
